// File: rtl/axis_pkg.sv
// Shared types and elaboration helpers for the AXI-Stream width converter.
//   conv_mode_e   : which datapath the top elaborates (equal / upsize / downsize)
//   ds_state_e    : downsize core FSM states
//   keep_lanes()  : byte lanes for a data width
//   clog2_ratio() : counter width for a width ratio (never below 1 bit)
//   width_ratio() : larger width over smaller width
//   conv_mode()   : mode from the two widths
package axis_pkg;

    typedef enum logic [1:0] {
        MODE_EQUAL = 2'd0,
        MODE_UP    = 2'd1,
        MODE_DOWN  = 2'd2
    } conv_mode_e;

    typedef enum logic {
        DS_IDLE = 1'b0,
        DS_HOLD = 1'b1
    } ds_state_e;

    function automatic int keep_lanes(input int w);
        return w / 8;
    endfunction

    function automatic int clog2_ratio(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

    function automatic int width_ratio(input int s_w, input int m_w);
        return (s_w > m_w) ? (s_w / m_w) : (m_w / s_w);
    endfunction

    function automatic conv_mode_e conv_mode(input int s_w, input int m_w);
        if (m_w > s_w) return MODE_UP;
        if (s_w > m_w) return MODE_DOWN;
        return MODE_EQUAL;
    endfunction

endpackage

// File: rtl/axis_downsize_core.sv
// Wide-to-narrow AXI-Stream splitter: holds one wide beat and emits it as
// M_W-wide sub-beats, lane 0 first, dropping trailing all-empty sub-beats of
// a tlast beat.
// Ports:
//   clk_i, rst_ni            clock, async active-low reset
//   run_i                    high once reset has been released
//   s_valid_i/s_ready_o      wide side handshake; s_data_i, s_keep_i, s_last_i
//   m_valid_o/m_ready_i      narrow side handshake; m_data_o, m_keep_o, m_last_o
//
// state   | meaning
// DS_IDLE | no beat held; ready for a wide beat
// DS_HOLD | wide beat held; sub-beat idx_q is on the master port
module axis_downsize_core
    import axis_pkg::*;
#(
    parameter int S_W = 128,
    parameter int M_W = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  run_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    input  logic [S_W-1:0]        s_data_i,
    input  logic [S_W/8-1:0]      s_keep_i,
    input  logic                  s_last_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [M_W-1:0]        m_data_o,
    output logic [M_W/8-1:0]      m_keep_o,
    output logic                  m_last_o
);
    localparam int SK    = keep_lanes(S_W);
    localparam int MK    = keep_lanes(M_W);
    localparam int RATIO = S_W / M_W;
    localparam int CW    = clog2_ratio(RATIO);

    ds_state_e       state_q, state_d;
    logic [CW-1:0]   idx_q, idx_d;
    logic [S_W-1:0]  data_q, data_d;
    logic [SK-1:0]   keep_q, keep_d, keep_nxt;
    logic            last_q, last_d;
    logic [M_W-1:0]  sub_data;
    logic [MK-1:0]   sub_keep;
    logic            next_empty, final_sub, s_fire;

    // keep of the sub-beat after idx_q sits at the same offset once shifted
    assign keep_nxt = keep_q >> MK;

    always_comb begin
        sub_data   = '0;
        sub_keep   = '0;
        next_empty = 1'b1;
        for (int k = 0; k < RATIO; k++) begin
            if (idx_q == CW'(k)) begin
                sub_data   = data_q[k*M_W +: M_W];
                sub_keep   = keep_q[k*MK +: MK];
                next_empty = (keep_nxt[k*MK +: MK] == '0);
            end
        end
    end

    assign final_sub = (idx_q == CW'(RATIO - 1)) || (last_q && next_empty);
    assign s_ready_o = run_i && ((state_q == DS_IDLE) || (m_ready_i && final_sub));
    assign s_fire    = s_valid_i && s_ready_o;

    assign m_valid_o = (state_q == DS_HOLD);
    assign m_data_o  = sub_data;
    assign m_keep_o  = sub_keep;
    assign m_last_o  = last_q && final_sub;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        keep_d  = keep_q;
        last_d  = last_q;
        if (state_q == DS_HOLD && m_ready_i) begin
            if (final_sub) state_d = DS_IDLE;
            else           idx_d   = idx_q + CW'(1);
        end
        // a new beat may land on the final sub-beat handshake: no bubble
        if (s_fire) begin
            state_d = DS_HOLD;
            idx_d   = '0;
            data_d  = s_data_i;
            keep_d  = s_keep_i;
            last_d  = s_last_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= DS_IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: rtl/axis_width_conv.sv
// AXI-Stream data-width converter with tkeep/tlast. Upsizes, downsizes or
// acts as a one-stage register slice depending on the two widths. Byte lane 0
// is the earliest byte on the stream.
// Ports:
//   clk, rst                           clock, async active-low reset
//   s_axis_tvalid/tready/tdata/tkeep/tlast   slave stream (S_TDATA_WIDTH)
//   m_axis_tvalid/tready/tdata/tkeep/tlast   master stream (M_TDATA_WIDTH)
module axis_width_conv
    import axis_pkg::*;
#(
    parameter int S_TDATA_WIDTH = 32,
    parameter int M_TDATA_WIDTH = 128
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic [S_TDATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [S_TDATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                       s_axis_tlast,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [M_TDATA_WIDTH-1:0]   m_axis_tdata,
    output logic [M_TDATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                       m_axis_tlast
);
    localparam int         SK    = keep_lanes(S_TDATA_WIDTH);
    localparam int         MK    = keep_lanes(M_TDATA_WIDTH);
    localparam int         RATIO = width_ratio(S_TDATA_WIDTH, M_TDATA_WIDTH);
    localparam conv_mode_e MODE  = conv_mode(S_TDATA_WIDTH, M_TDATA_WIDTH);

    if ((S_TDATA_WIDTH % 8 != 0) || (M_TDATA_WIDTH % 8 != 0) ||
        ((S_TDATA_WIDTH > M_TDATA_WIDTH) ? (S_TDATA_WIDTH % M_TDATA_WIDTH != 0)
                                         : (M_TDATA_WIDTH % S_TDATA_WIDTH != 0))) begin : g_bad_params
        $fatal(1, "axis_width_conv: widths must be byte multiples and integer ratios");
    end

    // Holds s_axis_tready low until the first clock after reset release.
    logic run_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) run_q <= 1'b0;
        else      run_q <= 1'b1;
    end

    if (MODE == MODE_EQUAL) begin : g_equal
        logic                     vld_q, last_q;
        logic [M_TDATA_WIDTH-1:0] data_q;
        logic [MK-1:0]            keep_q;

        assign s_axis_tready = run_q && (!vld_q || m_axis_tready);

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                vld_q  <= 1'b0;
                data_q <= '0;
                keep_q <= '0;
                last_q <= 1'b0;
            end else if (s_axis_tvalid && s_axis_tready) begin
                vld_q  <= 1'b1;
                data_q <= s_axis_tdata;
                keep_q <= s_axis_tkeep;
                last_q <= s_axis_tlast;
            end else if (m_axis_tready) begin
                vld_q  <= 1'b0;
            end
        end

        assign m_axis_tvalid = vld_q;
        assign m_axis_tdata  = data_q;
        assign m_axis_tkeep  = keep_q;
        assign m_axis_tlast  = last_q;
    end else if (MODE == MODE_UP) begin : g_up
        localparam int CW = clog2_ratio(RATIO);

        logic [CW-1:0]            cnt_q, cnt_d;
        logic [M_TDATA_WIDTH-1:0] acc_data_q, acc_data_d, out_data_q, out_data_d, merged_data;
        logic [MK-1:0]            acc_keep_q, acc_keep_d, out_keep_q, out_keep_d, merged_keep;
        logic                     out_vld_q, out_vld_d, out_last_q, out_last_d;
        logic [S_TDATA_WIDTH-1:0] s_data_masked;
        logic                     s_fire, close_word;

        assign s_axis_tready = run_q && (!out_vld_q || m_axis_tready);
        assign s_fire        = s_axis_tvalid && s_axis_tready;
        assign close_word    = (cnt_q == CW'(RATIO - 1)) || s_axis_tlast;

        // Disabled bytes are zeroed so empty lanes always read back as 0.
        always_comb begin
            s_data_masked = '0;
            for (int b = 0; b < SK; b++)
                s_data_masked[b*8 +: 8] = s_axis_tkeep[b] ? s_axis_tdata[b*8 +: 8] : 8'h00;
        end

        always_comb begin
            merged_data = acc_data_q;
            merged_keep = acc_keep_q;
            for (int k = 0; k < RATIO; k++) begin
                if (cnt_q == CW'(k)) begin
                    merged_data[k*S_TDATA_WIDTH +: S_TDATA_WIDTH] = s_data_masked;
                    merged_keep[k*SK +: SK]                       = s_axis_tkeep;
                end
            end
        end

        // A closing beat is only accepted when the output register is empty
        // or draining, so the merged word can always move straight into it.
        always_comb begin
            cnt_d      = cnt_q;
            acc_data_d = acc_data_q;
            acc_keep_d = acc_keep_q;
            out_data_d = out_data_q;
            out_keep_d = out_keep_q;
            out_last_d = out_last_q;
            out_vld_d  = out_vld_q;
            if (out_vld_q && m_axis_tready) out_vld_d = 1'b0;
            if (s_fire) begin
                if (close_word) begin
                    out_data_d = merged_data;
                    out_keep_d = merged_keep;
                    out_last_d = s_axis_tlast;
                    out_vld_d  = 1'b1;
                    acc_data_d = '0;
                    acc_keep_d = '0;
                    cnt_d      = '0;
                end else begin
                    acc_data_d = merged_data;
                    acc_keep_d = merged_keep;
                    cnt_d      = cnt_q + CW'(1);
                end
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt_q      <= '0;
                acc_data_q <= '0;
                acc_keep_q <= '0;
                out_data_q <= '0;
                out_keep_q <= '0;
                out_last_q <= 1'b0;
                out_vld_q  <= 1'b0;
            end else begin
                cnt_q      <= cnt_d;
                acc_data_q <= acc_data_d;
                acc_keep_q <= acc_keep_d;
                out_data_q <= out_data_d;
                out_keep_q <= out_keep_d;
                out_last_q <= out_last_d;
                out_vld_q  <= out_vld_d;
            end
        end

        assign m_axis_tvalid = out_vld_q;
        assign m_axis_tdata  = out_data_q;
        assign m_axis_tkeep  = out_keep_q;
        assign m_axis_tlast  = out_last_q;
    end else begin : g_down
        axis_downsize_core #(
            .S_W (S_TDATA_WIDTH),
            .M_W (M_TDATA_WIDTH)
        ) u_core (
            .clk_i     (clk),
            .rst_ni    (rst),
            .run_i     (run_q),
            .s_valid_i (s_axis_tvalid),
            .s_ready_o (s_axis_tready),
            .s_data_i  (s_axis_tdata),
            .s_keep_i  (s_axis_tkeep),
            .s_last_i  (s_axis_tlast),
            .m_valid_o (m_axis_tvalid),
            .m_ready_i (m_axis_tready),
            .m_data_o  (m_axis_tdata),
            .m_keep_o  (m_axis_tkeep),
            .m_last_o  (m_axis_tlast)
        );
    end

endmodule
